// File: rtl/wb_commit_tracer.sv
// Commit trace FIFO behind MEM/WB. Retiring instructions are queued for a valid/ready consumer.
// Once an EBREAK is accepted, the unit drains the queue and then raises ohalt.
module wb_commit_tracer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  input  logic [31:0]              wb_pc,
  input  logic [31:0]              wb_instr,
  input  logic [4:0]               wb_rd,
  input  logic                     wb_regwrite,
  input  logic [31:0]              wb_data,
  input  logic                     trace_ready,
  output logic                     trace_valid,
  output logic [31:0]              trace_pc,
  output logic [31:0]              trace_instr,
  output logic [4:0]               trace_rd,
  output logic                     trace_we,
  output logic [31:0]              trace_data,
  output logic [$clog2(DEPTH):0]   trace_count,
  output logic [CNT_W-1:0]         retired,
  output logic                     overflow,
  output logic                     ohalt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  entry_t          mem [DEPTH];
  entry_t          wr_entry, head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  state_t          state;
  logic            full, push_req, pop, accept, drop;

  always_comb begin
    wr_entry       = '0;
    wr_entry.pc    = wb_pc;
    wr_entry.instr = wb_instr;
    wr_entry.rd    = wb_rd;
    wr_entry.we    = wb_regwrite && (wb_rd != 5'd0);
    wr_entry.data  = wr_entry.we ? wb_data : 32'd0;
  end

  assign trace_valid = (trace_count != '0);
  assign full        = (trace_count == FULL_CNT);
  assign push_req    = wb_valid && (state == RUN);
  assign pop         = trace_valid && trace_ready;
  // A pop frees the slot on the same edge, so a full FIFO can still accept.
  assign accept      = push_req && (!full || pop);
  assign drop        = push_req && full && !pop;

  // Storage content is unqualified; the head is masked while empty.
  assign head        = trace_valid ? mem[rd_ptr] : '0;
  assign trace_pc    = head.pc;
  assign trace_instr = head.instr;
  assign trace_rd    = head.rd;
  assign trace_we    = head.we;
  assign trace_data  = head.data;

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      trace_count <= '0;
      retired     <= '0;
      overflow    <= 1'b0;
      ohalt       <= 1'b0;
      state       <= RUN;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      case ({accept, pop})
        2'b10:   trace_count <= trace_count + (AW+1)'(1);
        2'b01:   trace_count <= trace_count - (AW+1)'(1);
        default: trace_count <= trace_count;
      endcase
      if (accept) retired  <= retired + CNT_W'(1);
      if (drop)   overflow <= 1'b1;
      case (state)
        RUN:    if (accept && wb_instr == EBREAK) state <= DRAIN;
        DRAIN:  if (trace_count == '0) begin
                  state <= HALTED;
                  ohalt <= 1'b1;
                end
        HALTED: state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_commit_tracer.sv
// Bench for wb_commit_tracer: vector table, directed halt/overflow sequences, random vs queue model.
module tb_wb_commit_tracer;
  localparam int DEPTH = 8;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 0;
  logic        rst;
  logic        wb_valid, wb_regwrite, trace_ready;
  logic [31:0] wb_pc, wb_instr, wb_data;
  logic [4:0]  wb_rd;
  logic        trace_valid, trace_we, overflow, ohalt;
  logic [31:0] trace_pc, trace_instr, trace_data, retired;
  logic [4:0]  trace_rd;
  logic [3:0]  trace_count;

  wb_commit_tracer #(.DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_data(wb_data), .trace_ready(trace_ready),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_instr(trace_instr),
    .trace_rd(trace_rd), .trace_we(trace_we), .trace_data(trace_data),
    .trace_count(trace_count), .retired(retired), .overflow(overflow), .ohalt(ohalt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(bit v, logic [31:0] pc, logic [31:0] instr, logic [4:0] rd,
                        bit rw, logic [31:0] d, bit rdy);
    wb_valid = v; wb_pc = pc; wb_instr = instr; wb_rd = rd;
    wb_regwrite = rw; wb_data = d; trace_ready = rdy;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(int cycles);
    rst = 0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (cycles) cyc();
    rst = 1;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc, instr, data;
    logic [4:0]  rd;
    logic        we;
  } ment_t;
  ment_t       q[$];
  logic [31:0] m_ret;
  bit          m_ovf;
  int          m_mode;   // 0 run, 1 drain, 2 halted

  function automatic void model_step();
    ment_t e;
    int    pre;
    bit    pp, preq, acc;
    if (!rst) begin
      q.delete(); m_ret = 0; m_ovf = 0; m_mode = 0;
      return;
    end
    pre  = q.size();
    pp   = (pre > 0) && trace_ready;
    preq = wb_valid && (m_mode == 0);
    acc  = preq && (pre < DEPTH || pp);
    if (pp) void'(q.pop_front());
    if (acc) begin
      e.pc = wb_pc; e.instr = wb_instr; e.rd = wb_rd;
      e.we = wb_regwrite && wb_rd != 0;
      e.data = e.we ? wb_data : 32'd0;
      q.push_back(e);
      m_ret = m_ret + 1;
    end
    if (preq && !acc) m_ovf = 1;
    if (m_mode == 1 && pre == 0) m_mode = 2;
    else if (m_mode == 0 && acc && wb_instr == EBREAK) m_mode = 1;
  endfunction

  task automatic check_model();
    check("rnd.count", trace_count, q.size());
    check("rnd.valid", trace_valid, q.size() > 0);
    check("rnd.retired", retired, m_ret);
    check("rnd.overflow", overflow, m_ovf);
    check("rnd.ohalt", ohalt, m_mode == 2);
    if (q.size() > 0) begin
      check("rnd.pc", trace_pc, q[0].pc);
      check("rnd.instr", trace_instr, q[0].instr);
      check("rnd.rd", trace_rd, q[0].rd);
      check("rnd.we", trace_we, q[0].we);
      check("rnd.data", trace_data, q[0].data);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          v;
    logic [31:0] pc, instr;
    logic [4:0]  rd;
    bit          rw;
    logic [31:0] d;
    bit          rdy;
    bit          e_valid;
    logic [31:0] e_pc;
    logic [4:0]  e_rd;
    bit          e_we;
    logic [31:0] e_data;
    int          e_count;
    int          e_ret;
  } vec_t;
  vec_t vt[7];

  initial begin
    logic [31:0] exp_instr[4];
    int          k;

    vt[0] = '{1, 32'h00, 32'h00A00293, 5, 1, 32'hA,        0, 1, 32'h00, 5,  1, 32'hA,        1, 1};
    vt[1] = '{1, 32'h04, 32'h00000013, 0, 1, 32'h1234,     1, 1, 32'h04, 0,  0, 32'h0,        1, 2};
    vt[2] = '{0, 32'h00, 32'h00000000, 0, 0, 32'h0,        0, 1, 32'h04, 0,  0, 32'h0,        1, 2};
    vt[3] = '{1, 32'h08, 32'h00000033, 3, 0, 32'h55,       1, 1, 32'h08, 3,  0, 32'h0,        1, 3};
    vt[4] = '{0, 32'h00, 32'h00000000, 0, 0, 32'h0,        1, 0, 32'h00, 0,  0, 32'h0,        0, 3};
    vt[5] = '{1, 32'h0C, 32'h00000FB3, 31, 1, 32'hFFFFFFFF, 1, 1, 32'h0C, 31, 1, 32'hFFFFFFFF, 1, 4};
    vt[6] = '{0, 32'h00, 32'h00000000, 0, 0, 32'h0,        1, 0, 32'h00, 0,  0, 32'h0,        0, 4};

    // reset state
    do_reset(2);
    check("reset.valid", trace_valid, 0);
    check("reset.count", trace_count, 0);
    check("reset.retired", retired, 0);
    check("reset.overflow", overflow, 0);
    check("reset.ohalt", ohalt, 0);
    check("reset.data", {trace_pc, trace_data}, 0);
    check("reset.rdwe", {trace_instr, trace_rd, trace_we}, 0);

    // table: single push, x0 suppression, hold under backpressure, ready-before-valid
    for (int i = 0; i < 7; i++) begin
      set_in(vt[i].v, vt[i].pc, vt[i].instr, vt[i].rd, vt[i].rw, vt[i].d, vt[i].rdy);
      cyc();
      check($sformatf("vec%0d.valid", i), trace_valid, vt[i].e_valid);
      check($sformatf("vec%0d.pc", i), trace_pc, vt[i].e_pc);
      check($sformatf("vec%0d.rd", i), trace_rd, vt[i].e_rd);
      check($sformatf("vec%0d.we", i), trace_we, vt[i].e_we);
      check($sformatf("vec%0d.data", i), trace_data, vt[i].e_data);
      check($sformatf("vec%0d.count", i), trace_count, vt[i].e_count);
      check($sformatf("vec%0d.retired", i), retired, vt[i].e_ret);
    end

    // overflow: 10 pushes into 8 slots, then in-order drain
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      set_in(1, i * 4, 32'h13, 1, 1, i, 0);
      cyc();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    check("ovf.count", trace_count, 8);
    check("ovf.retired", retired, 8);
    check("ovf.flag", overflow, 1);
    trace_ready = 1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d.valid", i), trace_valid, 1);
      check($sformatf("drain%0d.pc", i), trace_pc, i * 4);
      cyc();
    end
    check("drain.empty", trace_valid, 0);
    check("drain.ovf_sticky", overflow, 1);

    // simultaneous push/pop while full
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      set_in(1, i * 4, 32'h13, 2, 1, i, 0);
      cyc();
    end
    for (int i = 8; i < 12; i++) begin
      set_in(1, i * 4, 32'h13, 2, 1, i, 1);
      cyc();
      check($sformatf("full_pp%0d.count", i), trace_count, 8);
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    check("full_pp.overflow", overflow, 0);
    check("full_pp.retired", retired, 12);
    check("full_pp.head", trace_pc, 32'h10);

    // halt sequence
    do_reset(1);
    exp_instr[0] = 32'h00100093; exp_instr[1] = 32'h00200113;
    exp_instr[2] = 32'h00300193; exp_instr[3] = EBREAK;
    for (int i = 0; i < 4; i++) begin
      set_in(1, i * 4, exp_instr[i], 1, 1, i, 0);
      cyc();
    end
    for (int i = 4; i < 6; i++) begin
      set_in(1, i * 4, 32'h00400213, 4, 1, i, 0);
      cyc();
    end
    check("halt.count", trace_count, 4);
    check("halt.retired", retired, 4);
    check("halt.overflow_drain", overflow, 0);
    check("halt.ohalt_early", ohalt, 0);
    set_in(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("halt_pop%0d.instr", i), trace_instr, exp_instr[i]);
      cyc();
    end
    check("halt.count0", trace_count, 0);
    check("halt.ohalt_m", ohalt, 0);
    set_in(1, 32'h40, 32'h13, 1, 1, 1, 1);
    cyc();
    check("halt.ohalt_m1", ohalt, 1);
    cyc();
    check("halt.ignored_count", trace_count, 0);
    check("halt.ignored_ret", retired, 4);
    check("halt.ohalt_hold", ohalt, 1);

    // reset mid-halt
    do_reset(1);
    check("rst_halt.ohalt", ohalt, 0);
    check("rst_halt.retired", retired, 0);
    set_in(1, 32'h80, 32'h13, 6, 1, 32'h77, 0);
    cyc();
    set_in(0, 0, 0, 0, 0, 0, 0);
    check("rst_halt.accept_ret", retired, 1);
    check("rst_halt.accept_pc", trace_pc, 32'h80);

    // random vs model
    do_reset(1);
    model_step();
    q.delete(); m_ret = 0; m_ovf = 0; m_mode = 0;
    k = 0;
    for (int c = 0; c < 4000; c++) begin
      int rdy_pct;
      rdy_pct = ((c / 150) % 3 == 0) ? 15 : ((c / 150) % 3 == 1) ? 60 : 95;
      if (m_mode == 2) k++; else k = 0;
      rst = !(($urandom_range(0, 299) == 0) || k > 3);
      set_in($urandom_range(0, 3) != 0, $urandom,
             ($urandom_range(0, 59) == 0) ? EBREAK : $urandom,
             5'($urandom), $urandom_range(0, 1), $urandom,
             $urandom_range(0, 99) < rdy_pct);
      @(posedge clk);
      model_step();
      #1;
      check_model();
    end
    rst = 1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_commit_tracer.md
# wb_commit_tracer

Commit-trace unit on the downstream side of the CPU's MEM/WB register. Every retiring instruction is captured with its PC, encoding, destination register and writeback value into a small FIFO. The self-checking bench drains this FIFO through a valid/ready port instead of probing the register file. The unit also owns halt sequencing: after an EBREAK retires, it drains the trace and then raises `ohalt`.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries. Must be a power of two, at least 2.
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `wb_valid`  in  1  an instruction retires this cycle.
- `wb_pc`  in  32  PC of the retiring instruction.
- `wb_instr`  in  32  encoding of the retiring instruction.
- `wb_rd`  in  5  destination register.
- `wb_regwrite`  in  1  the instruction writes `wb_rd`.
- `wb_data`  in  32  writeback value (ALU result or load data).
- `trace_ready`  in  1  the consumer accepts the head entry.
- `trace_valid`  out  1  the head entry is valid.
- `trace_pc`, `trace_instr`  out  32 each  head entry fields.
- `trace_rd`  out  5  head entry destination register.
- `trace_we`  out  1  head entry performed an architectural write.
- `trace_data`  out  32  head entry value.
- `trace_count`  out  $clog2(DEPTH)+1  occupancy.
- `retired`  out  CNT_W  number of instructions accepted since reset.
- `overflow`  out  1  sticky; at least one retirement was dropped.
- `ohalt`  out  1  halt sequence complete.

## Operation
- Push condition: `wb_valid` high while in state RUN.
- Stored entry: {pc, instr, rd, we, data}.
  - `we` = `wb_regwrite && (wb_rd != 0)`.
  - `data` is forced to 0 when `we` is 0.
- Acceptance: a push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - On a full FIFO with no pop, the entry is dropped, `overflow` sets, and `retired` does not increment.
- `retired` increments by 1 on each accepted push and wraps modulo 2^CNT_W.
- Pop condition: `trace_valid && trace_ready`. The head advances on that edge.
- Head outputs hold stable while `trace_valid` is high and `trace_ready` is low.
- Pointers are log2(DEPTH) bits with natural wrap. Occupancy is tracked by a separate counter.
- FSM states: RUN, DRAIN, HALTED.
  - RUN → DRAIN: an accepted push with `wb_instr == 32'h00100073` (EBREAK). The EBREAK entry itself is stored.
  - DRAIN: `wb_valid` is ignored (no push, no count, no overflow); pops continue.
  - DRAIN → HALTED: when `trace_count == 0`.
  - HALTED: `ohalt` = 1; retirements are ignored. The only exit is reset.
  - If the EBREAK is dropped because of overflow, the unit stays in RUN.
- Reset (including mid-operation) clears pointers, `trace_count`, `retired`, `overflow`, and returns the FSM to RUN. Stored data is don't-care.

## Timing
- Reset values: `trace_valid` 0, `trace_count` 0, `retired` 0, `overflow` 0, `ohalt` 0. `trace_*` data outputs are 0.
- Latency: an entry pushed at edge N is visible at the head (`trace_valid` = 1) after edge N when the FIFO was empty. There is no combinational path from `wb_*` to `trace_*`.
- `trace_count` and `retired` are registered and reflect the edge just taken.
- Push and pop in the same cycle:
  - `trace_count` is unchanged.
  - At count 1, the new entry becomes the head after that edge.
- `ohalt` is registered. If `trace_count` reaches 0 at edge M, the FSM enters HALTED at edge M+1, and `ohalt` = 1 after M+1.
  - An EBREAK that is immediately popped gives a 2-cycle minimum from EBREAK retirement to `ohalt`.
- `trace_ready` may be asserted before `trace_valid`. Ready is never required to start a transfer.

## Test plan
- Reset and single push:
  - Hold `rst` = 0 for 2 cycles and check all outputs are 0.
  - Retire ADDI x5 (pc 0x0, instr 0x00A00293, data 0xA) with `trace_ready` = 0.
  - Next cycle: `trace_valid` = 1, rd 5, we 1, data 0x0000000A, count 1, retired 1.
- x0 suppression:
  - Retire instr 0x00000013 with `wb_regwrite` = 1, `wb_rd` = 0, `wb_data` = 0x1234.
  - Entry must read we 0, data 0.
- Backpressure and overflow at DEPTH = 8:
  - Retire 10 instructions back-to-back with `trace_ready` = 0.
  - Check count 8, retired 8, `overflow` = 1.
  - Then drain: PCs 0x0 through 0x1C must come out in order, with no gaps.
- Simultaneous push and pop while full:
  - Keep count at 8 and assert `trace_ready` together with `wb_valid` for 4 cycles.
  - Count stays 8, `overflow` stays 0, retired increments by 4.
- Halt sequence:
  - Retire 3 instructions, then EBREAK 0x00100073, then 2 more instructions, with `trace_ready` = 0.
  - Check count 4 and the FSM in DRAIN.
  - Assert `trace_ready`: 4 pops, last entry is the EBREAK.
  - `ohalt` = 1 exactly 1 cycle after count reaches 0; retired = 4.
- Reset mid-halt:
  - From HALTED, pulse `rst` low for 1 cycle.
  - Check `ohalt` = 0, retired 0, and the next retirement is accepted.
